// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin mux sequencer and its arbiter.
package rr_mux_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: searches last+1, last+2, ... wrapping.
module rr_pick
    import rr_mux_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    // Scan farthest-first so the nearest requester after last overwrites and wins.
    always_comb begin
        winner = last;
        any    = |req;
        for (int k = NCH; k >= 1; k--) begin
            if (req[last + SEL_W'(k)]) begin
                winner = last + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_mux_sequencer.sv
// Round-robin sequencer driving a 4:1 mux select, capturing its output and
// presenting it downstream with valid/ready, tagged with the source channel.
module rr_mux_sequencer
    import rr_mux_pkg::*;
#(
    parameter int DW  = 2,
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   gnt,
    output logic [SEL_W-1:0] sel,
    input  logic [DW-1:0]    y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [SEL_W-1:0] out_ch
);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] last_reg, last_next;
    logic             valid_reg, valid_next;
    logic [DW-1:0]    data_reg, data_next;
    logic [SEL_W-1:0] ch_reg, ch_next;

    logic [SEL_W-1:0] winner;
    logic             any_req;

    rr_pick u_pick (
        .req    (req),
        .last   (last_reg),
        .winner (winner),
        .any    (any_req)
    );

    // State and datapath registers; last resets to 3 so channel 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            last_reg  <= SEL_W'(NCH - 1);
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ch_reg    <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            ch_reg    <= ch_next;
        end
    end

    // Next-state logic: arbitrate in IDLE/HOLD, capture the mux output in SAMPLE.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        valid_next = valid_reg;
        data_next  = data_reg;
        ch_next    = ch_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    sel_next   = winner;
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                data_next  = y_in;
                ch_next    = sel_reg;
                last_next  = sel_reg;
                valid_next = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                // Requests are only looked at once the held sample is accepted.
                if (out_ready) begin
                    valid_next = 1'b0;
                    if (any_req) begin
                        sel_next   = winner;
                        state_next = SAMPLE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-hot grant decoded from state and select only (no path from req).
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_gnt
            assign gnt[gi] = (state_reg == SAMPLE) && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign sel       = sel_reg;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_ch    = ch_reg;

endmodule

// File: tb/tb_rr_mux_sequencer.sv
// Bench for rr_mux_sequencer: directed stimulus, expected transfers in a scoreboard queue.
module tb_rr_mux_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] y_in;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_data;
    logic [1:0] out_ch;

    logic [1:0] chan_data [4];

    typedef struct packed {
        logic [1:0] ch;
        logic [1:0] data;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    rr_mux_sequencer #(.DW(2), .NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    // Behavioural 4:1 mux feeding the sequencer.
    assign y_in = chan_data[sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [1:0] data);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every accepted output must match the next expected transfer.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("xfer_ch", 32'(out_ch), 32'(e.ch));
                check("xfer_data", 32'(out_data), 32'(e.data));
                $display("xfer ch=%0d data=%0d (expected ch=%0d data=%0d)",
                         out_ch, out_data, e.ch, e.data);
            end
        end
    end

    initial begin
        logic [1:0] fair_ch [5];
        fair_ch[0] = 2'd0; fair_ch[1] = 2'd1; fair_ch[2] = 2'd2;
        fair_ch[3] = 2'd3; fair_ch[4] = 2'd0;

        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        chan_data[0] = 2'd0; chan_data[1] = 2'd1; chan_data[2] = 2'd2; chan_data[3] = 2'd3;

        // Power-on reset
        tick; tick;
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sel",   32'(sel),       32'd0);
        check("rst_gnt",   32'(gnt),       32'd0);
        check("rst_ch",    32'(out_ch),    32'd0);
        check("rst_data",  32'(out_data),  32'd0);

        // Single request on channel 2
        chan_data[2] = 2'b10;
        req = 4'b0100; out_ready = 1'b1;
        push_exp(2'd2, 2'b10);
        tick;
        check("single_sel",   32'(sel),       32'd2);
        check("single_gnt",   32'(gnt),       32'b0100);
        check("single_valid0", 32'(out_valid), 32'd0);
        req = 4'b0000;
        tick;
        check("single_valid1", 32'(out_valid), 32'd1);
        check("single_data",   32'(out_data),  32'b10);
        check("single_ch",     32'(out_ch),    32'd2);
        check("single_gnt_hold", 32'(gnt),     32'd0);
        tick;
        check("single_idle_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of HOLD discards the sample
        out_ready = 1'b0; req = 4'b0010;
        tick;
        check("prerst_sel", 32'(sel), 32'd1);
        req = 4'b0000;
        tick;
        check("prerst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_sel",   32'(sel),       32'd0);
        check("midrst_ch",    32'(out_ch),    32'd0);
        check("midrst_gnt",   32'(gnt),       32'd0);
        tick;
        rst = 1'b0;

        // Fairness: all four request, out_ready high, one sample every 2 cycles
        chan_data[0] = 2'd0; chan_data[1] = 2'd1; chan_data[2] = 2'd2; chan_data[3] = 2'd3;
        req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_exp(fair_ch[i], fair_ch[i]);
        for (int k = 1; k <= 10; k++) begin
            tick;
            check("fair_valid", 32'(out_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 1) begin
                check("fair_gnt", 32'(gnt), 32'd1 << fair_ch[(k - 1) / 2]);
            end
        end
        req = 4'b0000;
        tick;
        check("fair_end_valid", 32'(out_valid), 32'd0);

        // Backpressure: sample frozen while out_ready low and y_in moves
        chan_data[2] = 2'b01;
        out_ready = 1'b0; req = 4'b0100;
        push_exp(2'd2, 2'b01);
        tick;
        check("bp_gnt", 32'(gnt), 32'b0100);
        req = 4'b0000;
        tick;
        for (int k = 0; k < 5; k++) begin
            chan_data[2] = (k % 2 == 0) ? 2'b11 : 2'b10;
            tick;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data",  32'(out_data),  32'b01);
            check("bp_ch",    32'(out_ch),    32'd2);
            check("bp_gnt0",  32'(gnt),       32'd0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("bp_after_xfer", 32'(out_valid), 32'd0);
        tick;
        check("bp_no_repeat", 32'(out_valid), 32'd0);

        // Rotation skip: make last=1, then req=0011 grants ch0 then ch1
        chan_data[0] = 2'b11; chan_data[1] = 2'b00;
        out_ready = 1'b1; req = 4'b0010;
        push_exp(2'd1, 2'b00);
        tick;
        check("rot_pre_sel", 32'(sel), 32'd1);
        req = 4'b0000;
        tick; tick;
        req = 4'b0011;
        push_exp(2'd0, 2'b11);
        push_exp(2'd1, 2'b00);
        tick;
        check("rot_sel0", 32'(sel), 32'd0);
        check("rot_gnt0", 32'(gnt), 32'b0001);
        tick;
        tick;
        check("rot_sel1", 32'(sel), 32'd1);
        check("rot_gnt1", 32'(gnt), 32'b0010);
        req = 4'b0000;
        tick; tick;
        check("rot_idle", 32'(out_valid), 32'd0);

        // Request dropped right after arbitration: capture still happens
        chan_data[3] = 2'b10;
        req = 4'b1000;
        push_exp(2'd3, 2'b10);
        tick;
        check("drop_sel", 32'(sel), 32'd3);
        check("drop_gnt", 32'(gnt), 32'b1000);
        req = 4'b0000;
        tick;
        check("drop_valid", 32'(out_valid), 32'd1);
        check("drop_ch",    32'(out_ch),    32'd3);
        tick;
        check("drop_idle", 32'(out_valid), 32'd0);
        tick;
        check("drop_idle2", 32'(out_valid), 32'd0);
        check("drop_gnt0",  32'(gnt),       32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
